multicycle_invert_negate: RTL and testbench

MULTICYCLE_INVERT_NEGATE -- requirements
Module: multicycle_invert_negate

---
 rtl/multicycle_invert_negate.sv | 69 ++++++
 tb/tb_multicycle_invert_negate.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_invert_negate.sv
// multicycle_invert_negate: bitwise NOT or two's-complement negate, CHUNK bits per cycle
// Ports: clock, reset_n (async, active-low); in_valid/in_ready/data_in/mode accept an operand
// (mode 0 = NOT, 1 = negate); out_valid/out_ready/data_out deliver the result, with
// overflow (negate of the most-negative value) and zero flags valid only while out_valid.
module multicycle_invert_negate #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, next_state;
    logic [IW-1:0] idx;
    logic carry;
    logic mode_r;
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] res;
    logic [CHUNK:0] sum;
    logic last;
    // Negate is NOT plus one: seeding the carry with mode injects that +1 into chunk 0.
    assign sum = {1'b0, ~op[int'(idx)*CHUNK +: CHUNK]} + (CHUNK+1)'(carry);
    assign last = idx == IW'(NCHUNK - 1);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = (state == IDLE) ? (in_valid ? BUSY : IDLE) :
                     (state == BUSY) ? (last ? DONE : BUSY) :
                     (out_ready ? IDLE : DONE);
    end
    always_comb begin
        in_ready = state == IDLE;
        out_valid = state == DONE;
        data_out = out_valid ? res : '0;
        overflow = out_valid && mode_r && op == {1'b1, {(WIDTH-1){1'b0}}};
        zero = out_valid && res == '0;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idx <= '0;
            carry <= 1'b0;
            mode_r <= 1'b0;
            op <= '0;
            res <= '0;
        end else if (state == IDLE && in_valid) begin
            idx <= '0;
            carry <= mode;
            mode_r <= mode;
            op <= data_in;
        end else if (state == BUSY) begin
            res[int'(idx)*CHUNK +: CHUNK] <= sum[CHUNK-1:0];
            carry <= sum[CHUNK];
            idx <= last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_multicycle_invert_negate.sv
// tb_multicycle_invert_negate: directed self-checking bench for multicycle_invert_negate
module tb_multicycle_invert_negate;
    logic clock = 1'b0;
    logic reset_n;
    logic in_valid;
    logic in_ready;
    logic [31:0] data_in;
    logic mode;
    logic out_valid;
    logic out_ready;
    logic [31:0] data_out;
    logic overflow;
    logic zero;
    int checks = 0;
    int errors = 0;

    multicycle_invert_negate #(.WIDTH(32), .CHUNK(8)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_in(data_in),
        .mode(mode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out(data_out),
        .overflow(overflow),
        .zero(zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check(tag, 32'(out_valid), 32'd1);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic do_op(input string tag, input logic m, input logic [31:0] d,
                         input logic [31:0] e, input logic eo, input logic ez);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data_in = d;
        mode = m;
        @(negedge clock);
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            data_in = $urandom;
            mode = ~m;
            @(negedge clock);
        end
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        @(negedge clock);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, data_out, e);
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
        @(negedge clock);
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
        check({tag, "_flags"}, {30'd0, overflow, zero}, 32'd0);
    endtask

    logic [31:0] b2b_op [3] = '{32'h00000001, 32'hA5A5A5A5, 32'h00010000};
    logic [31:0] b2b_ex [3] = '{32'hFFFFFFFF, 32'h5A5A5A5B, 32'hFFFF0000};

    initial begin
        int k, last_cyc;
        reset_n = 1'b0;
        in_valid = 1'b0;
        data_in = '0;
        mode = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_flags", {30'd0, overflow, zero}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        do_op("not_ff", 1'b0, 32'h000000FF, 32'hFFFFFF00, 1'b0, 1'b0);
        do_op("neg_1", 1'b1, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0);
        do_op("neg_100", 1'b1, 32'h00000100, 32'hFFFFFF00, 1'b0, 1'b0);
        do_op("neg_0", 1'b1, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
        do_op("neg_min", 1'b1, 32'h80000000, 32'h80000000, 1'b1, 1'b0);
        do_op("not_all1", 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1);
        do_op("not_min", 1'b0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0);
        do_op("neg_min1", 1'b1, 32'h80000001, 32'h7FFFFFFF, 1'b0, 1'b0);

        // Stall in DONE while a new operand is offered; it must wait for IDLE.
        out_ready = 1'b0;
        in_valid = 1'b1;
        data_in = 32'h0F0F0F0F;
        mode = 1'b0;
        @(negedge clock);
        data_in = 32'h11111111;
        mode = 1'b1;
        wait_valid("stall_wait");
        for (int i = 0; i < 3; i++) begin
            check("stall_data", data_out, 32'hF0F0F0F0);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_valid", 32'(out_valid), 32'd1);
            @(negedge clock);
        end
        out_ready = 1'b1;
        @(negedge clock);
        check("stall_exit_idle", 32'(in_ready), 32'd1);
        check("stall_exit_novld", 32'(out_valid), 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
        check("stall_taken", 32'(in_ready), 32'd0);
        wait_valid("stall_wait2");
        check("stall_second", data_out, 32'hEEEEEEEF);
        @(negedge clock);

        // Reset asserted during the second BUSY cycle aborts the operation.
        in_valid = 1'b1;
        data_in = 32'h12345678;
        mode = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", data_out, 32'd0);
        check("abort_flags", {30'd0, overflow, zero}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_no_result", 32'(out_valid), 32'd0);
        do_op("post_rst", 1'b0, 32'h12345678, 32'hEDCBA987, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high.
        k = 0;
        last_cyc = 0;
        in_valid = 1'b1;
        mode = 1'b1;
        data_in = b2b_op[0];
        for (int cyc = 1; cyc <= 40 && k < 3; cyc++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                check("b2b_data", data_out, b2b_ex[k]);
                if (k > 0) check("b2b_period", 32'(cyc - last_cyc), 32'd6);
                last_cyc = cyc;
                k++;
                if (k < 3) data_in = b2b_op[k];
                else in_valid = 1'b0;
            end
        end
        check("b2b_count", 32'(k), 32'd3);
        @(negedge clock);
        check("b2b_idle", 32'(in_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
